silu_grad_pwl: RTL and testbench
================================

Name: silu_grad_pwl

Overview:
- Backward-pass counterpart of the SiLU forward PWL activation unit. Used on the training datapath.
- Takes the forward input x and the upstream gradient g, both Q8.8 signed 16-bit.
- Returns g * SiLU'(x), where SiLU'(x) comes from a piecewise-constant derivative LUT.
- Streaming valid/ready pipeline with 3-cycle latency, global stall under backpressure, and a saturation event counter.

Parameters:
- SEGS, 32: number of derivative LUT segments. The breakpoint and value tables in the package are sized by this.
- FRAC, 8: fractional bits of x, g and the result. The derivative also uses FRAC fractional bits.
- CNT_W, 16: width of the saturation event counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat this cycle
- in_x  in  16  forward input x, signed Q8.8
- in_g  in  16  upstream gradient dL/dy, signed Q8.8
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts the result
- out_dx  out  16  dL/dx, signed Q8.8, saturated
- sat_cnt  out  CNT_W  number of saturated results; sticks at all-ones
- sat_clr  in  1  synchronous clear of sat_cnt

Behaviour:
- Reset (rst=1 at a clock edge):
  - all stage valid bits and sat_cnt clear to 0;
  - out_dx = 0, out_valid = 0.
  - in_ready is combinational and equals 1 while out_valid = 0.
  - A reset mid-stream discards every in-flight beat. No partial result is emitted.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall.
  - An input beat transfers when in_valid & in_ready.
  - An output beat transfers when out_valid & out_ready.
  - While stall is high, every stage register, including the data registers, holds its value.
  - out_dx stays stable while out_valid=1 and out_ready=0.
- Pipeline (register enable = ~stall):
  - S1: segment lookup of in_x. Registers d (signed 10-bit Q2.8), g, and the valid bit v1 = in_valid & in_ready.
  - S2: registers the signed product p = g * d (26 bits, Q10.16) and v2.
  - S3: rounds and saturates, then registers out_dx and out_valid.
  - Latency is 3 cycles from input acceptance to out_valid when there is no stall. Throughput is 1 beat/cycle.
  - Bubbles are allowed: invalid beats advance, so out_valid may drop between beats.
- Derivative lookup:
  - Find the first i with x < BRK[i] (signed compare); d = DVAL[i]. If no breakpoint matches, d = DVAL[SEGS-1].
  - Mandatory anchor values:
    - x < 0xF800 (-8.0): d = 0x000.
    - Segment containing x = 0: d = 0x080 (0.5).
    - x >= 0x0800 (+8.0): d = 0x100 (1.0).
    - Maximum table value is 0x11A (about 1.10), near x = +2.4.
    - Minimum table value is 0x3E7 (-0.10 as 10-bit two's complement), near x = -2.4.
- Rounding and saturation:
  - r = (p + 2^(FRAC-1)) >>> FRAC (arithmetic shift; round half up).
  - If r > 0x7FFF, out_dx = 0x7FFF. If r < -0x8000, out_dx = 0x8000. Either case is a saturation event.
- Saturation counter:
  - sat_cnt increments by 1 when a saturating beat is loaded into S3. It stops at 2^CNT_W-1 and does not wrap.
  - sat_clr has priority over a simultaneous increment and forces the counter to 0.
  - While stalled, the counter counts each beat only once, at S3 load.

Decomposition:
- Package silu_pkg holds: Q-format constants (FRAC, data width 16, derivative width 10), the SILU_D_BRK and SILU_D_VAL arrays, and the saturation bounds.
- One combinational sub-module, silu_grad_lut, maps x to d. The top level instantiates it in S1.

Test Plan:
- Reset, then in_x=0x0000, in_g=0x0100, out_ready=1 -> out_valid rises exactly 3 cycles after acceptance; out_dx=0x0080. sat_cnt=0.
- in_x=0xF000 (-16), in_g=0x7FFF -> out_dx=0x0000. in_x=0x0900, in_g=0x1234 -> out_dx=0x1234.
- in_x at the d=0x11A peak, in_g=0x7FFF -> out_dx=0x7FFF and sat_cnt=1. Same x with in_g=0x8000 -> out_dx=0x8000, sat_cnt=2. Pulse sat_cnt's clear together with a third saturating beat -> sat_cnt=0.
- Stream 8 back-to-back beats and hold out_ready=0 for 5 cycles mid-stream:
  - in_ready drops while out_valid is held;
  - out_dx stays stable during the hold;
  - all 8 results emerge in order with no loss or duplication.
- Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 the next cycle and no stale beat appears later. sat_cnt=0.
- Random x/g sweep against a golden model (same table, round, saturate) over 10k beats, with random in_valid/out_ready -> bit-exact match.

Source files
------------

// File: rtl/silu_pkg.sv
// Shared Q-format constants, derivative tables and the round/saturate helper for silu_grad_pwl.
package silu_pkg;

    localparam int unsigned SEGS   = 32;
    localparam int unsigned FRAC   = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DER_W  = 10;
    localparam int unsigned PROD_W = DATA_W + DER_W;

    // Upper (exclusive) bound of each segment, signed Q8.8. The last entry is a sentinel;
    // x values past it fall back to the final table value anyway.
    localparam logic signed [DATA_W-1:0] SILU_D_BRK [SEGS] = '{
        16'hF800, 16'hFA00, 16'hFC00, 16'hFC80, 16'hFD00, 16'hFD40, 16'hFDC0, 16'hFE00,
        16'hFE40, 16'hFE80, 16'hFEC0, 16'hFF00, 16'hFF40, 16'hFF80, 16'hFFC0, 16'h0040,
        16'h0080, 16'h00C0, 16'h0100, 16'h0140, 16'h0180, 16'h01C0, 16'h0200, 16'h0240,
        16'h02C0, 16'h0300, 16'h0380, 16'h0400, 16'h0500, 16'h0600, 16'h0800, 16'h7FFF
    };

    // SiLU'(x) per segment, signed Q2.8. Dips to -0.10 near x=-2.4, peaks at 1.10 near x=+2.4.
    localparam logic signed [DER_W-1:0] SILU_D_VAL [SEGS] = '{
        10'h000, 10'h3FE, 10'h3F8, 10'h3F0, 10'h3EC, 10'h3E8, 10'h3E7, 10'h3E8,
        10'h3EB, 10'h3F0, 10'h3FA, 10'h005, 10'h021, 10'h03A, 10'h05F, 10'h080,
        10'h0A1, 10'h0C6, 10'h0DF, 10'h0FB, 10'h106, 10'h110, 10'h115, 10'h118,
        10'h11A, 10'h118, 10'h115, 10'h110, 10'h10A, 10'h105, 10'h101, 10'h100
    };

    localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;

    // Bounds and rounding constant at the widened product width.
    localparam logic signed [PROD_W:0] RS_HI    = (PROD_W+1)'(32767);
    localparam logic signed [PROD_W:0] RS_LO    = (PROD_W+1)'(-32768);
    localparam logic signed [PROD_W:0] RND_HALF = (PROD_W+1)'(1) << (FRAC - 1);

    typedef struct packed {
        logic              sat;
        logic [DATA_W-1:0] dx;
    } rs_t;

    // Round half up, drop FRAC bits, clamp to Q8.8 and flag clamping.
    function automatic rs_t round_sat(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W:0] sum;
        logic signed [PROD_W:0] r;
        rs_t res;
        sum = {p[PROD_W-1], p} + RND_HALF;
        r   = sum >>> FRAC;
        res.sat = 1'b0;
        res.dx  = r[DATA_W-1:0];
        if (r > RS_HI) begin
            res.sat = 1'b1;
            res.dx  = SAT_MAX;
        end else if (r < RS_LO) begin
            res.sat = 1'b1;
            res.dx  = SAT_MIN;
        end
        return res;
    endfunction

endpackage

// File: rtl/silu_grad_lut.sv
// Combinational piecewise-constant SiLU derivative lookup: first segment with x < BRK[i].
module silu_grad_lut
    import silu_pkg::*;
(
    input  logic signed [DATA_W-1:0] x,
    output logic signed [DER_W-1:0]  d
);

    // Scan from the top down so the lowest matching segment wins.
    always_comb begin
        d = SILU_D_VAL[SEGS-1];
        for (int i = SEGS - 1; i >= 0; i--) begin
            if (x < SILU_D_BRK[i]) begin
                d = SILU_D_VAL[i];
            end
        end
    end

endmodule

// File: rtl/silu_grad_pwl.sv
// SiLU backward PWL unit: dx = sat(round(g * SiLU'(x))), 3-stage streaming pipeline with
// global stall and a sticky saturation event counter.
module silu_grad_pwl
    import silu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_g,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_dx,
    output logic [CNT_W-1:0]  sat_cnt,
    input  logic              sat_clr
);

    logic                     stall;
    logic signed [DER_W-1:0]  lut_d;
    logic                     v1_q;
    logic signed [DER_W-1:0]  d1_q;
    logic signed [DATA_W-1:0] g1_q;
    logic                     v2_q;
    logic signed [PROD_W-1:0] p2_q;
    logic signed [PROD_W-1:0] prod;
    logic                     out_valid_q;
    logic [DATA_W-1:0]        out_dx_q;
    logic [CNT_W-1:0]         sat_cnt_q;
    logic                     sat_inc;
    rs_t                      rs;

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;

    silu_grad_lut u_lut (
        .x (in_x),
        .d (lut_d)
    );

    // S2 multiply and S3 round/saturate; an event counts only when the beat loads into S3.
    always_comb begin
        prod    = PROD_W'(g1_q) * PROD_W'(d1_q);
        rs      = round_sat(p2_q);
        sat_inc = ~stall & v2_q & rs.sat;
    end

    // S1: register looked-up derivative, gradient and valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            d1_q <= '0;
            g1_q <= '0;
        end else if (!stall) begin
            v1_q <= in_valid & in_ready;
            d1_q <= lut_d;
            g1_q <= in_g;
        end
    end

    // S2: register the full-precision product.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q <= 1'b0;
            p2_q <= '0;
        end else if (!stall) begin
            v2_q <= v1_q;
            p2_q <= prod;
        end
    end

    // S3: register the rounded, saturated result; held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_dx_q    <= '0;
        end else if (!stall) begin
            out_valid_q <= v2_q;
            out_dx_q    <= rs.dx;
        end
    end

    // Saturation counter: clear wins over increment, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else if (sat_clr) begin
            sat_cnt_q <= '0;
        end else if (sat_inc && (sat_cnt_q != '1)) begin
            sat_cnt_q <= sat_cnt_q + CNT_W'(1);
        end
    end

    assign out_valid = out_valid_q;
    assign out_dx    = out_dx_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_silu_grad_pwl.sv
// Self-checking bench for silu_grad_pwl: directed table, saturation/clear, stall, reset, random.
module tb_silu_grad_pwl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_g;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_dx;
    logic [15:0] sat_cnt;
    logic        sat_clr;

    int n_vec = 0;
    int n_err = 0;

    // Derivative curve in plain integers: segment upper bounds (x*256) and SiLU'(x)*256.
    localparam int BRK [31] = '{
        -2048, -1536, -1024, -896, -768, -704, -576, -512, -448, -384, -320, -256, -192, -128,
        -64, 64, 128, 192, 256, 320, 384, 448, 512, 576, 704, 768, 896, 1024, 1280, 1536, 2048
    };
    localparam int DV [32] = '{
        0, -2, -8, -16, -20, -24, -25, -24, -21, -16, -6, 5, 33, 58, 95, 128,
        161, 198, 223, 251, 262, 272, 277, 280, 282, 280, 277, 272, 266, 261, 257, 256
    };

    typedef struct {
        logic [15:0] x;
        logic [15:0] g;
        logic [15:0] dx;
    } vec_t;

    silu_grad_pwl #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_g      (in_g),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dx    (out_dx),
        .sat_cnt   (sat_cnt),
        .sat_clr   (sat_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_dx(input logic [15:0] x, input logic [15:0] g,
                                             output bit sat);
        int xi;
        int d;
        int p;
        int r;
        bit found;
        xi    = int'($signed(x));
        d     = DV[31];
        found = 1'b0;
        for (int i = 0; i < 31; i++) begin
            if (!found && xi < BRK[i]) begin
                d     = DV[i];
                found = 1'b1;
            end
        end
        p   = int'($signed(g)) * d;
        r   = (p + 128) >>> 8;
        sat = 1'b0;
        if (r > 32767) begin
            r   = 32767;
            sat = 1'b1;
        end else if (r < -32768) begin
            r   = -32768;
            sat = 1'b1;
        end
        return r[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One isolated beat; optionally pulses sat_clr on the edge that loads it into S3.
    task automatic send_beat(input logic [15:0] x, input logic [15:0] g, input bit clr,
                             output logic [15:0] dx, output int lat);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_x      = x;
        in_g      = g;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
            lat++;
            sat_clr = clr && (lat == 2);
        end
        sat_clr = 1'b0;
        dx      = out_dx;
    endtask

    initial begin
        vec_t        vt [13];
        logic [15:0] dx;
        int          lat;
        bit          s;

        vt[0]  = '{16'h0000, 16'h0100, 16'h0080};
        vt[1]  = '{16'hF000, 16'h7FFF, 16'h0000};
        vt[2]  = '{16'h0900, 16'h1234, 16'h1234};
        vt[3]  = '{16'hF7FF, 16'h7FFF, 16'h0000};
        vt[4]  = '{16'hF800, 16'h7FFF, 16'hFF00};
        vt[5]  = '{16'h07FF, 16'h0100, 16'h0101};
        vt[6]  = '{16'h0800, 16'h0100, 16'h0100};
        vt[7]  = '{16'hFD99, 16'h0100, 16'hFFE7};
        vt[8]  = '{16'h0000, 16'h0001, 16'h0001};
        vt[9]  = '{16'h0000, 16'hFFFF, 16'h0000};
        vt[10] = '{16'h0040, 16'h0100, 16'h00A1};
        vt[11] = '{16'hFFC0, 16'h0100, 16'h0080};
        vt[12] = '{16'h0300, 16'h0100, 16'h0115};

        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_g = '0; out_ready = 1'b1; sat_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_dx", out_dx, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        check("rst_in_ready", in_ready, 1);

        // Directed table, one beat at a time.
        for (int i = 0; i < 13; i++) begin
            send_beat(vt[i].x, vt[i].g, 1'b0, dx, lat);
            check($sformatf("vec%0d_dx", i), dx, vt[i].dx);
            check($sformatf("vec%0d_latency", i), lat, 3);
        end
        check("vec_sat_cnt", sat_cnt, 0);

        // Saturation at the derivative peak, then clear racing a third saturating beat.
        send_beat(16'h0266, 16'h7FFF, 1'b0, dx, lat);
        check("sat_pos_dx", dx, 16'h7FFF);
        check("sat_pos_cnt", sat_cnt, 1);
        send_beat(16'h0266, 16'h8000, 1'b0, dx, lat);
        check("sat_neg_dx", dx, 16'h8000);
        check("sat_neg_cnt", sat_cnt, 2);
        send_beat(16'h0266, 16'h7FFF, 1'b1, dx, lat);
        check("sat_clr_dx", dx, 16'h7FFF);
        check("sat_clr_cnt", sat_cnt, 0);

        // Eight back-to-back beats with a 5-cycle downstream hold mid-stream.
        begin
            logic [15:0] sx [8];
            logic [15:0] sg [8];
            logic [15:0] se [8];
            logic [15:0] prev_dx;
            bit          prev_hold;
            int          idx;
            int          nout;
            int          c;
            int          extra;
            for (int i = 0; i < 8; i++) begin
                sx[i] = 16'(i * 96 - 300);
                sg[i] = 16'(256 + i * 37);
                se[i] = model_dx(sx[i], sg[i], s);
            end
            idx = 0; nout = 0; c = 0; prev_hold = 1'b0; prev_dx = '0;
            while (nout < 8 && c < 60) begin
                @(posedge clk); #1;
                out_ready = !(c >= 4 && c < 9);
                in_valid  = (idx < 8);
                if (idx < 8) begin
                    in_x = sx[idx];
                    in_g = sg[idx];
                end
                @(negedge clk);
                if (prev_hold) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_dx", out_dx, prev_dx);
                end
                if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
                prev_hold = out_valid && !out_ready;
                prev_dx   = out_dx;
                if (in_valid && in_ready) idx++;
                if (out_valid && out_ready) begin
                    check($sformatf("stream%0d_dx", nout), out_dx, se[nout]);
                    nout++;
                end
                c++;
            end
            check("stream_count", nout, 8);
            extra = 0;
            repeat (4) begin
                @(posedge clk); #1;
                in_valid  = 1'b0;
                out_ready = 1'b1;
                @(negedge clk);
                if (out_valid) extra++;
            end
            check("stream_extra", extra, 0);
        end

        // Reset with three saturating beats in flight and the output stalled.
        begin
            int stale;
            @(posedge clk); #1;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_x      = 16'h0266;
            in_g      = 16'h7FFF;
            repeat (3) @(posedge clk);
            #1 in_valid = 1'b0; rst = 1'b1;
            @(negedge clk);
            check("pre_rst_valid", out_valid, 1);
            check("pre_rst_sat_cnt", sat_cnt, 1);
            @(posedge clk); #1;
            rst       = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            check("post_rst_valid", out_valid, 0);
            check("post_rst_in_ready", in_ready, 1);
            check("post_rst_sat_cnt", sat_cnt, 0);
            stale = 0;
            repeat (6) begin
                @(posedge clk);
                @(negedge clk);
                if (out_valid) stale++;
            end
            check("post_rst_stale", stale, 0);
        end

        // Random sweep against the model with random valid/ready.
        begin
            logic [15:0] expq [$];
            logic [15:0] prev_dx;
            bit          prev_hold;
            int          exp_sat;
            int          sent;
            int          got;
            int          cyc;
            localparam int N = 10000;
            exp_sat = 0; sent = 0; got = 0; cyc = 0; prev_hold = 1'b0; prev_dx = '0;
            while ((sent < N || got < sent) && cyc < 60000) begin
                @(posedge clk); #1;
                in_valid = (sent < N) && ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) != 0) in_x = 16'($urandom);
                else in_x = 16'($urandom_range(0, 4608)) - 16'd2304;
                in_g      = 16'($urandom);
                out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (prev_hold) begin
                    check("rand_hold_valid", out_valid, 1);
                    check("rand_hold_dx", out_dx, prev_dx);
                end
                prev_hold = out_valid && !out_ready;
                prev_dx   = out_dx;
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rand_spurious: got beat %0h, expected none", out_dx);
                    end else begin
                        check("rand_dx", out_dx, expq.pop_front());
                        got++;
                    end
                end
                if (in_valid && in_ready) begin
                    expq.push_back(model_dx(in_x, in_g, s));
                    if (s) exp_sat++;
                    sent++;
                end
                cyc++;
            end
            check("rand_drained", got, N);
            check("rand_sat_cnt", sat_cnt, exp_sat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
